hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Hazard-detection / stall controller for the 5-stage MIPS pipeline; the producer-side counterpart of the forwarding unit: it handles every hazard forwarding cannot resolve.
- Detects load-use and branch-in-ID operand hazards.
- Tracks the busy window of the multicycle multiply/divide unit.
- Drives PC/IF-ID write enables and the ID/EX bubble insert.

Parameters:
MULT_LAT, 4, cycles from mult/multu in EX until HI/LO valid (>=1)
DIV_LAT, 32, cycles from div/divu in EX until HI/LO valid (>=1)
CNT_W, 6, busy-counter width; must hold max(MULT_LAT,DIV_LAT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is beq/bne/jr (compares/reads in ID)
id_hilo_rd  in  1  ID instruction is mfhi/mflo
id_md  in  1  ID instruction is mult/multu/div/divu
ex_rd  in  5  destination register in EX
ex_regwrite  in  1  EX instruction writes GPR
ex_memread  in  1  EX instruction is a load
ex_md_start  in  1  multiply/divide entering EX this cycle
ex_md_div  in  1  qualifies ex_md_start: 1=divide, 0=multiply
mem_rd  in  5  destination register in MEM
mem_memread  in  1  MEM instruction is a load
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID register write enable
idex_bubble  out  1  zero control bits into ID/EX
md_busy  out  1  multiply/divide result pending
md_done  out  1  one-cycle pulse when HI/LO becomes valid

Behaviour:
- Match rule: X(r) = (r != 0) and the stage writes r.
- load_use = ex_memread & ex_regwrite & ((id_use_rs & X(id_rs)==ex_rd) | (id_use_rt & X(id_rt)==ex_rd)).
- br_haz = id_branch & [(ex_regwrite and EX rd matches a used ID source) or (mem_memread and MEM rd matches a used ID source)].
  - ALU producer in EX: 1 stall.
  - Load producer: 2 stalls (EX cycle, then MEM cycle).
- md_haz = (id_hilo_rd | id_md) & (md_busy | ex_md_start).
  - ex_md_start counts as busy in the same cycle, before the counter loads.
- stall = load_use | br_haz | md_haz.
  - pc_en = ~stall, ifid_en = ~stall, idex_bubble = stall; all combinational, zero added latency.
- Busy counter cnt[CNT_W-1:0], two states:
  - IDLE (cnt==0): on ex_md_start, load cnt = (ex_md_div ? DIV_LAT : MULT_LAT) and go to BUSY.
  - BUSY (cnt!=0): decrement each cycle.
  - At cnt==1 the next edge sets cnt=0; md_done=1 for exactly that following cycle; state returns to IDLE.
  - md_busy = (cnt != 0), registered.
- ex_md_start while BUSY: ignored, no reload. Cannot occur legally, because md_haz holds any md op in ID.
- md_done and ex_md_start in the same cycle: the new op loads normally; md_done still pulses.
- Reset:
  - cnt=0, md_busy=0, md_done=0.
  - While rst=1: pc_en=1, ifid_en=1, idex_bubble=0, regardless of inputs.
  - Reset mid-BUSY aborts the operation; no md_done pulse.
- Register 0 never causes a stall.
- Width: counter arithmetic is unsigned; LAT values are truncated to CNT_W. Elaboration fails if a LAT does not fit in CNT_W.

Optional Feature:
- HAZ_PERF_CNT_EN defined adds three outputs:
  - stall_cycles[31:0]: +1 per cycle with stall=1.
  - load_use_cnt[31:0]: +1 per cycle with load_use=1.
  - md_wait_cnt[31:0]: +1 per cycle with md_haz=1.
  - All three reset to 0, wrap modulo 2^32, and do not count while rst=1.
- HAZ_PERF_CNT_EN undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: MULT_LAT/DIV_LAT defaults, register-zero constant 5'd0, busy-state encoding (IDLE=0, BUSY=1).
- One sub-module, md_busy_tracker: counter, md_busy, md_done.
- Top level keeps the combinational hazard equations.

Test Plan:
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=8; id_rs=8, id_use_rs=1 -> stall=1 for one cycle (pc_en=0, ifid_en=0, idex_bubble=1); next cycle (load in MEM, no branch) stall=0. Repeat with ex_rd=0 -> no stall.
- Branch after load: beq in ID using rt=9; lw $9 in EX -> 2 consecutive stall cycles. Same with an addu writing $9 -> exactly 1 stall.
- Multiply latency, MULT_LAT=4: ex_md_start=1, ex_md_div=0 at cycle 0 -> md_busy high cycles 1-4, md_done=1 at cycle 5. mflo held in ID cycles 0-4 stalls; released at cycle 5.
- Divide, DIV_LAT=32: md_busy high for 32 cycles. Second div in ID stalls until md_done. Extra ex_md_start injected while BUSY -> cnt unchanged.
- Reset mid-divide: rst at cycle 10 of 32 -> md_busy=0, pc_en=1 next cycle, no md_done pulse.
- HAZ_PERF_CNT_EN: run the load-use plus mult/mflo sequence -> stall_cycles=6, load_use_cnt=1, md_wait_cnt=5.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants and busy-state encoding for the hazard/stall controller.
package hazard_stall_unit_pkg;

  localparam int unsigned MULT_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF  = 32;
  localparam logic [4:0]  REG_ZERO     = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// Multiply/divide busy window: loads the op latency, counts down, pulses md_done.
module md_busy_tracker
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy,
  output logic md_done
);

  if (MULT_LAT < 1 || (MULT_LAT >> CNT_W) != 0) begin : g_bad_mult_lat
    $error("MULT_LAT must be >= 1 and fit in CNT_W bits");
  end
  if (DIV_LAT < 1 || (DIV_LAT >> CNT_W) != 0) begin : g_bad_div_lat
    $error("DIV_LAT must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      md_done <= done_nx;
    end
  end

  // A start arriving while BUSY is ignored; the ID-side hazard prevents it legally.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          cnt_nx   = md_div ? DIV_LD : MULT_LD;
          state_nx = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_nx = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          done_nx  = 1'b1;
          state_nx = MD_IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = MD_IDLE;
      end
    endcase
  end

  assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection / stall control for the 5-stage pipeline.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_branch,
  input  logic        id_hilo_rd,
  input  logic        id_md,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_md_start,
  input  logic        ex_md_div,
  input  logic [4:0]  mem_rd,
  input  logic        mem_memread,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic        md_done
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] load_use_cnt,
  output logic [31:0] md_wait_cnt
`endif
);

  function automatic logic hit(input logic [4:0] src, input logic en, input logic [4:0] dst);
    return en && (src != REG_ZERO) && (src == dst);
  endfunction

  logic src_ex, src_mem;
  logic load_use, br_haz, md_haz, stall;

  assign src_ex  = hit(id_rs, id_use_rs, ex_rd)  | hit(id_rt, id_use_rt, ex_rd);
  assign src_mem = hit(id_rs, id_use_rs, mem_rd) | hit(id_rt, id_use_rt, mem_rd);

  assign load_use = ex_memread & ex_regwrite & src_ex;
  assign br_haz   = id_branch & ((ex_regwrite & src_ex) | (mem_memread & src_mem));
  assign md_haz   = (id_hilo_rd | id_md) & (md_busy | ex_md_start);

  // Reset forces the pipeline to run regardless of hazard inputs.
  assign stall       = ~rst & (load_use | br_haz | md_haz);
  assign pc_en       = ~stall;
  assign ifid_en     = ~stall;
  assign idex_bubble = stall;

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_tracker (
    .clk      (clk),
    .rst      (rst),
    .md_start (ex_md_start),
    .md_div   (ex_md_div),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      load_use_cnt <= '0;
      md_wait_cnt  <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall);
      load_use_cnt <= load_use_cnt + 32'(load_use);
      md_wait_cnt  <= md_wait_cnt + 32'(md_haz);
    end
  end
`endif

endmodule
